// File: rtl/cs_stream_bist.sv
// Self-test harness for the CS moving-window filter: resets CS, streams stimulus
// from a ROM onto X and checks Y against a golden ROM, reporting mismatch count.
module cs_stream_bist #(
  parameter int unsigned N_PAT   = 2000,
  parameter int unsigned WIN     = 9,
  parameter int unsigned Y_LAT   = 1,
  parameter int unsigned RST_CYC = 2,
  parameter int unsigned AW      = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          cs_reset,
  output logic [7:0]    X,
  input  logic [9:0]    Y,
  output logic [AW-1:0] x_addr,
  input  logic [7:0]    x_rdata,
  output logic [AW-1:0] g_addr,
  input  logic [9:0]    g_rdata,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [15:0]   err_cnt,
  output logic [15:0]   first_err_idx
);

  localparam int unsigned NCMP = N_PAT - WIN + 1;
  localparam int unsigned KW   = AW + 1;
  localparam int unsigned RCW  = (RST_CYC < 2) ? 1 : $clog2(RST_CYC);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CSRST = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [KW-1:0]    k_q, k_n;
  logic [RCW-1:0]   rst_cnt, rc_n;
  logic [15:0]      cmp_idx, ci_n;
  logic [Y_LAT-1:0] pipe_q, pipe_n;
  logic             cs_n, busy_n, done_n, pass_n;
  logic [7:0]       x_n;
  logic [AW-1:0]    xa_n, ga_n;
  logic [15:0]      err_n, fe_n;

  // Compare pipeline: stage 0 is "X now holds a compare-eligible sample",
  // stage Y_LAT is the edge where the matching Y is sampled.
  logic             cand_c, cmp_c, gadv_c, miss_c;
  logic [Y_LAT:0]   stg_c;

  assign cand_c = (state == S_RUN) && (k_q >= KW'(WIN - 1));
  assign stg_c  = {pipe_q, cand_c};
  assign cmp_c  = stg_c[Y_LAT];
  assign gadv_c = stg_c[Y_LAT-1];
  assign miss_c = cmp_c && (Y !== g_rdata);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      cs_reset      <= 1'b0;
      X             <= '0;
      x_addr        <= '0;
      g_addr        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_cnt       <= '0;
      first_err_idx <= 16'hFFFF;
      k_q           <= '0;
      rst_cnt       <= '0;
      cmp_idx       <= '0;
      pipe_q        <= '0;
    end else begin
      state         <= state_n;
      cs_reset      <= cs_n;
      X             <= x_n;
      x_addr        <= xa_n;
      g_addr        <= ga_n;
      busy          <= busy_n;
      done          <= done_n;
      pass          <= pass_n;
      err_cnt       <= err_n;
      first_err_idx <= fe_n;
      k_q           <= k_n;
      rst_cnt       <= rc_n;
      cmp_idx       <= ci_n;
      pipe_q        <= pipe_n;
    end
  end

  always_comb begin
    state_n = state;
    cs_n    = cs_reset;
    x_n     = X;
    xa_n    = x_addr;
    ga_n    = g_addr;
    k_n     = k_q;
    rc_n    = rst_cnt;
    ci_n    = cmp_idx;
    err_n   = err_cnt;
    fe_n    = first_err_idx;
    done_n  = done;
    pass_n  = pass;
    pipe_n  = stg_c[Y_LAT-1:0];

    if (cmp_c) begin
      ci_n = cmp_idx + 16'd1;
      if (miss_c) begin
        if (err_cnt != 16'hFFFF) err_n = err_cnt + 16'd1;
        if (err_cnt == 16'd0)    fe_n  = cmp_idx;
      end
    end
    // Golden address moves one edge before its compare so g_rdata lines up with Y.
    if (gadv_c && (g_addr < AW'(NCMP - 1))) ga_n = g_addr + AW'(1);

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n = S_CSRST;
          cs_n    = 1'b1;
          x_n     = '0;
          xa_n    = '0;
          ga_n    = '0;
          k_n     = '0;
          rc_n    = '0;
          ci_n    = '0;
          err_n   = '0;
          fe_n    = 16'hFFFF;
          done_n  = 1'b0;
          pass_n  = 1'b0;
          pipe_n  = '0;
        end
      end
      S_CSRST: begin
        // Address 0 is read in the second-to-last reset cycle, address 1 in the last.
        xa_n = (32'(rst_cnt) + 32'd2 >= RST_CYC) ? x_addr + AW'(1) : '0;
        if (rst_cnt == RCW'(RST_CYC - 1)) begin
          state_n = S_RUN;
          cs_n    = 1'b0;
          x_n     = x_rdata;
          k_n     = '0;
        end else begin
          rc_n = rst_cnt + RCW'(1);
        end
      end
      S_RUN: begin
        if (x_addr < AW'(N_PAT - 1)) xa_n = x_addr + AW'(1);
        if (k_q == KW'(N_PAT - 1)) begin
          state_n = S_DRAIN;
        end else begin
          x_n = x_rdata;
          k_n = k_q + KW'(1);
        end
      end
      S_DRAIN: begin
        if (cmp_c && (cmp_idx == 16'(NCMP - 1))) begin
          state_n = S_DONE;
          done_n  = 1'b1;
          pass_n  = (err_n == 16'd0);
        end
      end
      default: state_n = S_IDLE;
    endcase

    busy_n = (state_n == S_CSRST) || (state_n == S_RUN) || (state_n == S_DRAIN);
  end

endmodule

// File: tb/tb_cs_stream_bist.sv
// Bench for cs_stream_bist: ROM and CS models around the harness, vector table of
// whole-test scenarios checked through a result scoreboard, plus reset/restart sequences.
module tb_cs_stream_bist;

  localparam int unsigned N_PAT   = 2000;
  localparam int unsigned WIN     = 9;
  localparam int unsigned Y_LAT   = 1;
  localparam int unsigned RST_CYC = 2;
  localparam int unsigned AW      = 15;
  localparam int unsigned NCMP    = N_PAT - WIN + 1;
  localparam int unsigned LAT     = RST_CYC + N_PAT + Y_LAT;
  localparam int          BUDGET  = 2500;
  localparam int          NVEC    = 5;

  logic          clk = 1'b0;
  logic          reset, start;
  logic          cs_reset;
  logic [7:0]    X;
  logic [9:0]    Y;
  logic [AW-1:0] x_addr, g_addr;
  logic [7:0]    x_rdata;
  logic [9:0]    g_rdata;
  logic          busy, done, pass;
  logic [15:0]   err_cnt, first_err_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cs_stream_bist #(.N_PAT(N_PAT), .WIN(WIN), .Y_LAT(Y_LAT), .RST_CYC(RST_CYC), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .cs_reset(cs_reset), .X(X), .Y(Y),
    .x_addr(x_addr), .x_rdata(x_rdata), .g_addr(g_addr), .g_rdata(g_rdata),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .first_err_idx(first_err_idx)
  );

  logic [7:0] stim      [2**AW];
  logic [9:0] gold_base [2**AW];
  logic [9:0] gold_rom  [2**AW];

  always_ff @(posedge clk) begin
    x_rdata <= stim[x_addr];
    g_rdata <= gold_rom[g_addr];
  end

  function automatic logic [9:0] filt(input logic [8*WIN-1:0] w);
    int unsigned s = 0;
    for (int i = 0; i < int'(WIN); i++) s += 32'(w[8*i +: 8]);
    return 10'(s >> 2);
  endfunction

  // Ideal registered CS filter, or a stuck-at-3FF stub when cs_mode == 1.
  int               cs_mode;
  logic [8*WIN-1:0] win_q;
  logic [9:0]       y_ideal;
  always_ff @(posedge clk) begin
    if (cs_reset) begin
      win_q   <= '0;
      y_ideal <= '0;
    end else begin
      win_q   <= {win_q[8*WIN-9:0], X};
      y_ideal <= filt({win_q[8*WIN-9:0], X});
    end
  end
  assign Y = (cs_mode == 1) ? 10'h3FF : y_ideal;

  // Protocol monitor, restarted on each rising cs_reset.
  int   rst_seen, xi, xerr, max_x, max_g;
  logic cs_prev = 1'b0;
  always @(negedge clk) begin
    if (cs_reset) begin
      if (!cs_prev) begin
        rst_seen = 0; xi = 0; xerr = 0; max_x = 0; max_g = 0;
      end
      rst_seen++;
    end else if (busy) begin
      if (xi < int'(N_PAT)) begin
        if (X !== stim[AW'(xi)]) xerr++;
      end else if (X !== stim[AW'(N_PAT - 1)]) begin
        xerr++;
      end
      xi++;
    end
    if (busy) begin
      if (int'(x_addr) > max_x) max_x = int'(x_addr);
      if (int'(g_addr) > max_g) max_g = int'(g_addr);
    end
    cs_prev = cs_reset;
  end

  typedef struct {
    logic [15:0] err;
    logic [15:0] first;
    logic        pass;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    int          mode;
    int          bad_a;
    int          bad_b;
    logic [15:0] err;
    logic [15:0] first;
    logic        pass;
  } vec_t;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic load_gold(input int a, input int b);
    for (int j = 0; j < int'(NCMP); j++) gold_rom[AW'(j)] = gold_base[AW'(j)];
    if (a >= 0) gold_rom[AW'(a)] = gold_rom[AW'(a)] ^ 10'h001;
    if (b >= 0) gold_rom[AW'(b)] = gold_rom[AW'(b)] ^ 10'h001;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " cs_reset"}, 32'(cs_reset), 32'd0);
    chk({tag, " X"}, 32'(X), 32'd0);
    chk({tag, " x_addr"}, 32'(x_addr), 32'd0);
    chk({tag, " g_addr"}, 32'(g_addr), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " pass"}, 32'(pass), 32'd0);
    chk({tag, " err_cnt"}, 32'(err_cnt), 32'd0);
    chk({tag, " first_err_idx"}, 32'(first_err_idx), 32'hFFFF);
  endtask

  // Called #1 after a posedge; start is seen by the DUT at the next posedge.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int inject, output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    for (int c = 1; c <= BUDGET; c++) begin
      if (c == inject) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      if (done) begin
        lat = c;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_test(input string tag, input logic [15:0] e_err, input logic [15:0] e_first,
                          input logic e_pass, input int inject, input bit check_clear);
    exp_t e, g;
    int   lat;
    bit   ok;
    e.err = e_err; e.first = e_first; e.pass = e_pass; e.lat = int'(LAT);
    sb_q.push_back(e);
    pulse_start();
    if (check_clear) begin
      chk({tag, " done_dropped"}, 32'(done), 32'd0);
      chk({tag, " err_cleared"}, 32'(err_cnt), 32'd0);
      chk({tag, " first_cleared"}, 32'(first_err_idx), 32'hFFFF);
      chk({tag, " busy_on"}, 32'(busy), 32'd1);
    end
    wait_done(inject, lat, ok);
    chk({tag, " done_in_budget"}, 32'(ok), 32'd1);
    g = sb_q.pop_front();
    chk({tag, " err_cnt"}, 32'(err_cnt), 32'(g.err));
    chk({tag, " first_err_idx"}, 32'(first_err_idx), 32'(g.first));
    chk({tag, " pass"}, 32'(pass), 32'(g.pass));
    chk({tag, " latency"}, 32'(lat), 32'(g.lat));
    chk({tag, " cs_reset_cycles"}, 32'(rst_seen), 32'(RST_CYC));
    chk({tag, " x_stream_errs"}, 32'(xerr), 32'd0);
    chk({tag, " x_cycles"}, 32'(xi), 32'(N_PAT + Y_LAT));
    chk({tag, " max_x_addr"}, 32'(max_x), 32'(N_PAT - 1));
    chk({tag, " max_g_addr"}, 32'(max_g), 32'(NCMP - 1));
  endtask

  initial begin
    logic [8*WIN-1:0] w;
    reset   = 1'b1;
    start   = 1'b0;
    cs_mode = 0;
    for (int i = 0; i < 2**AW; i++) begin
      stim[AW'(i)]      = (i < int'(N_PAT)) ? 8'($urandom_range(0, 255)) : 8'h00;
      gold_base[AW'(i)] = '0;
    end
    for (int j = 0; j < int'(NCMP); j++) begin
      for (int i = 0; i < int'(WIN); i++) w[8*i +: 8] = stim[AW'(j + i)];
      gold_base[AW'(j)] = filt(w);
    end
    load_gold(-1, -1);

    vecs[0] = '{0, -1,   -1,   16'd0,    16'hFFFF, 1'b1};
    vecs[1] = '{0, 37,   1500, 16'd2,    16'd37,   1'b0};
    vecs[2] = '{1, -1,   -1,   16'd1992, 16'd0,    1'b0};
    vecs[3] = '{0, 0,    1991, 16'd2,    16'd0,    1'b0};
    vecs[4] = '{0, 1991, -1,   16'd1,    16'd1991, 1'b0};

    repeat (3) @(posedge clk);
    #1 check_reset("por");
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int v = 0; v < NVEC; v++) begin
      cs_mode = vecs[v].mode;
      load_gold(vecs[v].bad_a, vecs[v].bad_b);
      run_test($sformatf("vec%0d", v), vecs[v].err, vecs[v].first, vecs[v].pass, 0, 1'b0);
    end

    // Asynchronous reset while streaming around k=500, then a clean rerun.
    cs_mode = 0;
    load_gold(-1, -1);
    pulse_start();
    @(negedge clk);
    #1;
    for (int c = 0; c < BUDGET && xi < 500; c++) begin
      @(posedge clk);
      #1;
    end
    chk("midrun reached_k500", 32'(xi >= 500), 32'd1);
    chk("midrun busy_before", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1 check_reset("midrun");
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    run_test("after_reset", 16'd0, 16'hFFFF, 1'b1, 0, 1'b0);

    // start during RUN is ignored; start in DONE restarts with counters cleared.
    load_gold(37, 1500);
    run_test("start_in_run", 16'd2, 16'd37, 1'b0, 1000, 1'b0);
    load_gold(-1, -1);
    run_test("restart", 16'd0, 16'hFFFF, 1'b1, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
